// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronises rx_i, samples each bit at mid-bit, and holds the
// received byte in a one-entry valid/ready output register with frame-error and overrun flags.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 5,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  input  logic                 rx_en_i,
  input  logic                 clr_err_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CPB_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   fall;

  logic [1:0]             state, state_n;
  logic [CW-1:0]          clk_cnt, clk_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift_reg, shift_n;
  logic                   rxdone;
  logic                   ferr_n;

  assign rx_s        = sync_q[SYNC_STAGES-1];
  assign fall        = !rx_s && rx_prev;
  assign dbg_state_o = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev <= rx_s;
    end
  end

  always_comb begin
    state_n = state;
    clk_n   = clk_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    rxdone  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en_i && fall) begin
          state_n = START;
          clk_n   = '0;
        end
      end
      START: begin
        if (clk_cnt == HALF_C) begin
          clk_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          clk_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CPB_M1) begin
          clk_n   = '0;
          shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_n = STOP;
        end else begin
          clk_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CPB_M1) begin
          clk_n   = '0;
          state_n = IDLE;
          if (rx_s) rxdone = 1'b1;
          else      ferr_n = 1'b1;
        end else begin
          clk_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Disabling the receiver abandons any partial frame silently.
    if (!rx_en_i) begin
      state_n = IDLE;
      clk_n   = '0;
      rxdone  = 1'b0;
      ferr_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_n;
      bit_cnt     <= bit_n;
      shift_reg   <= shift_n;
      busy_o      <= (state_n != IDLE);
      frame_err_o <= ferr_n;
    end
  end

  // Handshake: a byte transfers on any posedge where valid_o && ready_i; data_o is
  // stable while valid_o=1, and a new byte arriving into a full, stalled register is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (rxdone) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift_reg;
          valid_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (rxdone && valid_o && !ready_i) overrun_o <= 1'b1;
      else if (clr_err_i)                overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: table of frames plus hand-written corner sequences,
// with a scoreboard queue checking every accepted byte.
module tb_uart_rx_deframer;

  localparam int CPB = 5;

  logic       clk;
  logic       reset;
  logic       rx_i;
  logic       rx_en_i;
  logic       clr_err_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
  logic [1:0] dbg_state_o;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i), .rx_en_i(rx_en_i), .clr_err_i(clr_err_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx_i = 1'b1;
  endtask

  // scoreboard: every accepted byte must match the head of exp_q
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (valid_o && ready_i) begin
          acc_cnt++;
          if (exp_q.size() == 0) check("unexpected_byte", {24'd0, data_o}, 32'hFFFF_FFFF);
          else check("rx_byte", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
        end
        if (frame_err_o) ferr_cnt++;
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_acc;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];
  int   acc_b, ferr_b;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h55, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b0, 0, 1};
    vecs[6] = '{8'h01, 1'b1, 1, 0};
    vecs[7] = '{8'hC3, 1'b1, 1, 0};

    reset = 1'b1; rx_i = 1'b1; rx_en_i = 1'b1; clr_err_i = 1'b0; ready_i = 1'b1;
    idle(3);
    check("rst_data",  {24'd0, data_o}, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'h0);
    check("rst_ferr",  {31'd0, frame_err_o}, 32'h0);
    check("rst_ovr",   {31'd0, overrun_o}, 32'h0);
    check("rst_busy",  {31'd0, busy_o}, 32'h0);
    check("rst_state", {30'd0, dbg_state_o}, 32'h0);
    reset = 1'b0;
    idle(4);

    // table-driven frames
    for (int i = 0; i < 8; i++) begin
      acc_b = acc_cnt; ferr_b = ferr_cnt;
      if (vecs[i].exp_acc != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_bit);
      idle(12);
      check("vec_acc",   acc_cnt - acc_b, vecs[i].exp_acc);
      check("vec_ferr",  ferr_cnt - ferr_b, vecs[i].exp_ferr);
      check("vec_valid", {31'd0, valid_o}, 32'h0);
      check("vec_busy",  {31'd0, busy_o}, 32'h0);
    end

    // glitch: start bit too short
    acc_b = acc_cnt; ferr_b = ferr_cnt;
    rx_i = 1'b0; idle(2); rx_i = 1'b1; tick();
    check("glitch_busy_hi", {31'd0, busy_o}, 32'h1);
    idle(6);
    check("glitch_busy_lo", {31'd0, busy_o}, 32'h0);
    check("glitch_acc",  acc_cnt - acc_b, 0);
    check("glitch_ferr", ferr_cnt - ferr_b, 0);

    // overrun with stalled consumer
    ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(12);
    check("ovr_valid", {31'd0, valid_o}, 32'h1);
    check("ovr_data",  {24'd0, data_o}, 32'h11);
    check("ovr_flag",  {31'd0, overrun_o}, 32'h1);
    ready_i = 1'b1; tick();
    check("ovr_consumed", {31'd0, valid_o}, 32'h0);
    check("ovr_sticky",   {31'd0, overrun_o}, 32'h1);
    clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
    check("ovr_cleared",  {31'd0, overrun_o}, 32'h0);
    check("ovr_queue",    exp_q.size(), 0);

    // back-to-back frames, no idle gap
    acc_b = acc_cnt; ferr_b = ferr_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(12);
    check("b2b_acc",  acc_cnt - acc_b, 2);
    check("b2b_ferr", ferr_cnt - ferr_b, 0);

    // reset during the 4th data bit of 0x81
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    rx_i = 1'b0; idle(2);
    check("mid_busy", {31'd0, busy_o}, 32'h1);
    reset = 1'b1; tick();
    check("mid_rst_data",  {24'd0, data_o}, 32'h0);
    check("mid_rst_valid", {31'd0, valid_o}, 32'h0);
    check("mid_rst_busy",  {31'd0, busy_o}, 32'h0);
    check("mid_rst_state", {30'd0, dbg_state_o}, 32'h0);
    rx_i = 1'b1; tick(); reset = 1'b0; idle(CPB * 8);
    acc_b = acc_cnt;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(12);
    check("post_rst_acc", acc_cnt - acc_b, 1);

    // disable mid-frame: silent abort, then normal reception
    acc_b = acc_cnt; ferr_b = ferr_cnt;
    drive_bit(1'b0); drive_bit(1'b1);
    rx_i = 1'b0; idle(2); rx_en_i = 1'b0; tick();
    check("dis_busy",  {31'd0, busy_o}, 32'h0);
    check("dis_state", {30'd0, dbg_state_o}, 32'h0);
    for (int i = 0; i < 6; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    idle(4);
    check("dis_acc",  acc_cnt - acc_b, 0);
    check("dis_ferr", ferr_cnt - ferr_b, 0);
    rx_en_i = 1'b1;
    exp_q.push_back(8'hE7);
    send_frame(8'hE7, 1'b1);
    idle(12);
    check("reen_acc", acc_cnt - acc_b, 1);

    // break: line held low gives a single frame error
    acc_b = acc_cnt; ferr_b = ferr_cnt;
    rx_i = 1'b0; idle(80);
    check("brk_ferr",  ferr_cnt - ferr_b, 1);
    check("brk_acc",   acc_cnt - acc_b, 0);
    check("brk_busy",  {31'd0, busy_o}, 32'h0);
    rx_i = 1'b1; idle(8);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    idle(12);
    check("brk_recover_acc", acc_cnt - acc_b, 1);
    check("final_queue", exp_q.size(), 0);
    check("final_ovr", {31'd0, overrun_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
